// File: rtl/ipv4_hdr_check.sv
// ----------------------------------------------------------------------------
// ipv4_hdr_check
//
// Purpose:
//   Checks one IPv4 header snapshot from the upstream Ethernet/IPv4 parser.
//   The header checksum is recomputed serially, one halfword per cycle.
//   The stage also checks version, IHL, TTL, L4 protocol and destination IP.
//   It returns one verdict per header over a valid/ready handshake.
//   Two saturating counters track good and bad verdicts.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   hdr_valid/ready    header snapshot handshake (ready only in IDLE)
//   vhdr .. desip      parsed IPv4 header fields
//   is_udp, is_tcp     parser L4 classification
//   res_valid/ready    verdict handshake
//   res_ok             header passed every enabled check
//   res_err            {dst_mis,bad_proto,ttl_zero,bad_csum,bad_ihl,bad_ver}
//   res_csum           folded ones-complement sum (16'hFFFF when correct)
//   pkt_cnt, err_cnt   saturating counts of good / bad verdicts
//   o_dbg_state        current FSM state (0 IDLE, 1 SUM, 2 FOLD, 3 DONE)
//
// Handshake:
//   A transfer occurs on a rising edge where valid and ready are both 1.
//   Once valid is raised, the producer holds it and the payload stable
//   until that transfer.
//
// Timing:
//   The header is accepted in cycle 0.
//   Cycles 1-10 (SUM) add one halfword each.
//   Cycle 11 (FOLD) folds the sum and registers the checks.
//   res_valid is high from cycle 12.
// ----------------------------------------------------------------------------
module ipv4_hdr_check #(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_00C7,
    parameter bit          CHECK_DST = 1'b1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hdr_valid,
    output logic             hdr_ready,
    input  logic [15:0]      vhdr,
    input  logic [15:0]      tlength,
    input  logic [15:0]      id,
    input  logic [15:0]      offset,
    input  logic [7:0]       ttl,
    input  logic [7:0]       protocol,
    input  logic [15:0]      headerchecksum,
    input  logic [31:0]      sourceip,
    input  logic [31:0]      desip,
    input  logic             is_udp,
    input  logic             is_tcp,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic [5:0]       res_err,
    output logic [15:0]      res_csum,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUM  = 2'd1,
        S_FOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [19:0]       r_acc;

    // Header snapshot, captured at accept so later input changes are ignored
    logic [15:0]       r_vhdr;
    logic [15:0]       r_tlength;
    logic [15:0]       r_id;
    logic [15:0]       r_offset;
    logic [7:0]        r_ttl;
    logic [7:0]        r_protocol;
    logic [15:0]       r_hcsum;
    logic [31:0]       r_src;
    logic [31:0]       r_dst;
    logic              r_is_udp;
    logic              r_is_tcp;

    logic              r_hdr_ready;
    logic              r_res_valid;
    logic              r_res_ok;
    logic [5:0]        r_res_err;
    logic [15:0]       r_res_csum;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [15:0]       w_hw;
    logic [16:0]       w_s1;
    logic [15:0]       w_fold;
    logic [5:0]        w_err;

    // Halfword selected for the current SUM cycle
    always_comb begin
        w_hw = 16'h0000;
        case (r_idx)
            4'd0:    w_hw = r_vhdr;
            4'd1:    w_hw = r_tlength;
            4'd2:    w_hw = r_id;
            4'd3:    w_hw = r_offset;
            4'd4:    w_hw = {r_ttl, r_protocol};
            4'd5:    w_hw = r_hcsum;
            4'd6:    w_hw = r_src[31:16];
            4'd7:    w_hw = r_src[15:0];
            4'd8:    w_hw = r_dst[31:16];
            4'd9:    w_hw = r_dst[15:0];
            default: w_hw = 16'h0000;
        endcase
    end

    // Two-step fold is exact for a 20-bit accumulator.
    // The first step leaves at most one carry for the second step.
    assign w_s1   = {1'b0, r_acc[15:0]} + {13'b0, r_acc[19:16]};
    assign w_fold = w_s1[15:0] + {15'b0, w_s1[16]};

    // Error vector bit order: {dst_mis,bad_proto,ttl_zero,bad_csum,bad_ihl,bad_ver}
    always_comb begin
        w_err    = 6'b000000;
        w_err[0] = (r_vhdr[15:12] != 4'd4);
        w_err[1] = (r_vhdr[11:8] != 4'd5);
        w_err[2] = (w_fold != 16'hFFFF);
        w_err[3] = (r_ttl == 8'd0);
        w_err[4] = ~(r_is_udp ^ r_is_tcp)
                 | (r_is_udp & (r_protocol != 8'h11))
                 | (r_is_tcp & (r_protocol != 8'h06));
        w_err[5] = CHECK_DST & (r_dst != LOCAL_IP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_acc       <= 20'd0;
            r_vhdr      <= 16'h0000;
            r_tlength   <= 16'h0000;
            r_id        <= 16'h0000;
            r_offset    <= 16'h0000;
            r_ttl       <= 8'h00;
            r_protocol  <= 8'h00;
            r_hcsum     <= 16'h0000;
            r_src       <= 32'h0;
            r_dst       <= 32'h0;
            r_is_udp    <= 1'b0;
            r_is_tcp    <= 1'b0;
            r_hdr_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_ok    <= 1'b0;
            r_res_err   <= 6'b000000;
            r_res_csum  <= 16'h0000;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hdr_valid && r_hdr_ready) begin
                        r_vhdr      <= vhdr;
                        r_tlength   <= tlength;
                        r_id        <= id;
                        r_offset    <= offset;
                        r_ttl       <= ttl;
                        r_protocol  <= protocol;
                        r_hcsum     <= headerchecksum;
                        r_src       <= sourceip;
                        r_dst       <= desip;
                        r_is_udp    <= is_udp;
                        r_is_tcp    <= is_tcp;
                        r_idx       <= 4'd0;
                        r_acc       <= 20'd0;
                        r_hdr_ready <= 1'b0;
                        r_state     <= S_SUM;
                    end
                end
                S_SUM: begin
                    r_acc <= r_acc + {4'b0000, w_hw};
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'd9) begin
                        r_state <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    r_res_csum  <= w_fold;
                    r_res_err   <= w_err;
                    r_res_ok    <= ~|w_err;
                    r_res_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    // Verdict transfers here; the counters move only on this cycle
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_hdr_ready <= 1'b1;
                        r_state     <= S_IDLE;
                        if (r_res_ok) begin
                            if (!(&r_pkt_cnt)) r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        end else begin
                            if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hdr_ready   = r_hdr_ready;
    assign res_valid   = r_res_valid;
    assign res_ok      = r_res_ok;
    assign res_err     = r_res_err;
    assign res_csum    = r_res_csum;
    assign pkt_cnt     = r_pkt_cnt;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ipv4_hdr_check.sv
module tb_ipv4_hdr_check;

  localparam logic [31:0] LIP = 32'hC0A8_00C7;

  typedef struct packed {
    logic [15:0] vhdr;
    logic [15:0] tlength;
    logic [15:0] id;
    logic [15:0] offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] csum;
    logic [31:0] src;
    logic [31:0] dst;
    logic        is_udp;
    logic        is_tcp;
  } hdr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hdr_valid, hdr_ready, res_valid, res_ready, res_ok;
  logic [15:0] vhdr, tlength, id, offset, headerchecksum, res_csum;
  logic [7:0]  ttl, protocol;
  logic [31:0] sourceip, desip;
  logic        is_udp, is_tcp;
  logic [5:0]  res_err;
  logic [15:0] pkt_cnt, err_cnt;
  logic [1:0]  dbg_state;

  // Second instance with 2-bit counters shares all inputs; only its counters are checked
  logic        hdr_ready2, res_valid2, res_ok2;
  logic [5:0]  res_err2;
  logic [15:0] res_csum2;
  logic [1:0]  pkt_cnt2, err_cnt2, dbg_state2;

  ipv4_hdr_check #(.LOCAL_IP(LIP), .CHECK_DST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .vhdr(vhdr), .tlength(tlength), .id(id), .offset(offset), .ttl(ttl),
    .protocol(protocol), .headerchecksum(headerchecksum), .sourceip(sourceip),
    .desip(desip), .is_udp(is_udp), .is_tcp(is_tcp), .res_valid(res_valid),
    .res_ready(res_ready), .res_ok(res_ok), .res_err(res_err), .res_csum(res_csum),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .o_dbg_state(dbg_state)
  );

  ipv4_hdr_check #(.LOCAL_IP(LIP), .CHECK_DST(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready2),
    .vhdr(vhdr), .tlength(tlength), .id(id), .offset(offset), .ttl(ttl),
    .protocol(protocol), .headerchecksum(headerchecksum), .sourceip(sourceip),
    .desip(desip), .is_udp(is_udp), .is_tcp(is_tcp), .res_valid(res_valid2),
    .res_ready(res_ready), .res_ok(res_ok2), .res_err(res_err2), .res_csum(res_csum2),
    .pkt_cnt(pkt_cnt2), .err_cnt(err_cnt2), .o_dbg_state(dbg_state2)
  );

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: ones-complement sum of all ten halfwords, folded until no carry remains
  function automatic void model(input hdr_t h, output logic [15:0] ecsum, output logic [5:0] eerr);
    int unsigned hw[10];
    int unsigned sum;
    bit ver_bad, ihl_bad, csum_bad, ttl_bad, proto_bad, dst_bad;
    hw = '{h.vhdr, h.tlength, h.id, h.offset, {h.ttl, h.protocol}, h.csum,
           h.src[31:16], h.src[15:0], h.dst[31:16], h.dst[15:0]};
    sum = 0;
    foreach (hw[k]) sum += hw[k];
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ecsum     = sum[15:0];
    ver_bad   = (h.vhdr >> 12) != 4;
    ihl_bad   = ((h.vhdr >> 8) & 16'hF) != 5;
    csum_bad  = (sum != 32'hFFFF);
    ttl_bad   = (h.ttl == 0);
    if (h.is_udp && !h.is_tcp)      proto_bad = (h.protocol != 8'd17);
    else if (h.is_tcp && !h.is_udp) proto_bad = (h.protocol != 8'd6);
    else                            proto_bad = 1'b1;
    dst_bad   = (h.dst != LIP);
    eerr = {dst_bad, proto_bad, ttl_bad, csum_bad, ihl_bad, ver_bad};
  endfunction

  // Correct checksum field for a header: complement of the folded sum of the other nine halfwords
  function automatic logic [15:0] good_csum(input hdr_t h);
    hdr_t t;
    logic [15:0] s;
    logic [5:0] e;
    t = h;
    t.csum = 16'h0000;
    model(t, s, e);
    return ~s;
  endfunction

  function automatic hdr_t t1_hdr();
    hdr_t h;
    h.vhdr = 16'h4500; h.tlength = 16'h0073; h.id = 16'h0000; h.offset = 16'h4000;
    h.ttl = 8'h40; h.protocol = 8'h11; h.csum = 16'hB861;
    h.src = 32'hC0A8_0001; h.dst = 32'hC0A8_00C7; h.is_udp = 1'b1; h.is_tcp = 1'b0;
    return h;
  endfunction

  function automatic hdr_t rand_hdr();
    hdr_t h;
    int pc;
    h.vhdr = {8'h45, 8'($urandom_range(0, 255))};
    if ($urandom_range(0, 5) == 0) h.vhdr = 16'($urandom());
    h.tlength  = 16'($urandom());
    h.id       = 16'($urandom());
    h.offset   = 16'($urandom());
    h.ttl      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    pc = $urandom_range(0, 5);
    case (pc)
      0, 1:    begin h.is_udp = 1'b1; h.is_tcp = 1'b0; h.protocol = 8'h11; end
      2, 3:    begin h.is_udp = 1'b0; h.is_tcp = 1'b1; h.protocol = 8'h06; end
      4:       begin h.is_udp = 1'($urandom()); h.is_tcp = h.is_udp; h.protocol = 8'h11; end
      default: begin h.is_udp = 1'($urandom()); h.is_tcp = ~h.is_udp; h.protocol = 8'($urandom()); end
    endcase
    h.src = $urandom();
    h.dst = ($urandom_range(0, 9) < 7) ? LIP : $urandom();
    h.csum = 16'h0000;
    h.csum = ($urandom_range(0, 9) < 7) ? good_csum(h) : 16'($urandom());
    return h;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input hdr_t h);
    vhdr = h.vhdr; tlength = h.tlength; id = h.id; offset = h.offset;
    ttl = h.ttl; protocol = h.protocol; headerchecksum = h.csum;
    sourceip = h.src; desip = h.dst; is_udp = h.is_udp; is_tcp = h.is_tcp;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hdr_ready"}, 32'(hdr_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_ok"},    32'(res_ok),    32'd0);
    chk({tag, "_res_err"},   32'(res_err),   32'd0);
    chk({tag, "_res_csum"},  32'(res_csum),  32'd0);
    chk({tag, "_pkt_cnt"},   32'(pkt_cnt),   32'd0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    chk({tag, "_pkt_cnt2"},  32'(pkt_cnt2),  32'd0);
  endtask

  // Called at a sample point in IDLE; returns at the sample point of cycle 1
  task automatic start_hdr(input hdr_t h);
    drive(h);
    hdr_valid = 1'b1;
    chk("hdr_ready_idle", 32'(hdr_ready), 32'd1);
    @(posedge clk); #1;
    chk("hdr_ready_busy", 32'(hdr_ready), 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [15:0] ec, input logic [5:0] ee);
    chk({tag, "_valid"},     32'(res_valid), 32'd1);
    chk({tag, "_ok"},        32'(res_ok),    32'(ee == 6'd0));
    chk({tag, "_err"},       32'(res_err),   32'(ee));
    chk({tag, "_csum"},      32'(res_csum),  32'(ec));
    chk({tag, "_hdr_ready"}, 32'(hdr_ready), 32'd0);
  endtask

  task automatic finish_hdr(input hdr_t h, input int stall, input bit hold, input hdr_t nxt);
    logic [15:0] ec;
    logic [5:0]  ee;
    int cyc;
    model(h, ec, ee);
    if (hold) begin
      drive(nxt);
    end else begin
      drive(rand_hdr());
      hdr_valid = 1'b0;
    end
    res_ready = (stall == 0);
    cyc = 1;
    while (res_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd12);
    check_res("verdict", ec, ee);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_res("stall", ec, ee);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    if (ee == 6'd0) exp_pkt++; else exp_err++;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("hdr_ready_back", 32'(hdr_ready), 32'd1);
    chk("pkt_cnt",  32'(pkt_cnt),  32'(exp_pkt));
    chk("err_cnt",  32'(err_cnt),  32'(exp_err));
    chk("pkt_cnt2", 32'(pkt_cnt2), 32'((exp_pkt > 3) ? 3 : exp_pkt));
    chk("err_cnt2", 32'(err_cnt2), 32'((exp_err > 3) ? 3 : exp_err));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    hdr_t t1, t2, t3, tb, cur, nxt, dummy;
    int stall;
    bit hold;

    rst = 1'b1;
    hdr_valid = 1'b0;
    res_ready = 1'b1;
    dummy = '0;
    drive(dummy);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: valid UDP header to the local address
    t1 = t1_hdr();
    start_hdr(t1);
    finish_hdr(t1, 0, 1'b0, dummy);

    // T2: checksum off by one
    t2 = t1;
    t2.csum = 16'hB862;
    start_hdr(t2);
    finish_hdr(t2, 0, 1'b0, dummy);

    // T3: IHL 6 with TCP classification on a UDP protocol number
    t3 = t1;
    t3.vhdr = 16'h4600;
    t3.is_tcp = 1'b1;
    t3.is_udp = 1'b0;
    start_hdr(t3);
    finish_hdr(t3, 0, 1'b0, dummy);

    // T4: back-pressure for 6 cycles with the next header already waiting
    tb = rand_hdr();
    start_hdr(t1);
    finish_hdr(t1, 6, 1'b1, tb);
    start_hdr(tb);
    finish_hdr(tb, 0, 1'b0, dummy);

    // T5: reset while the sum is at halfword index 4
    start_hdr(t1);
    hdr_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    exp_pkt = 0;
    exp_err = 0;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_hdr(t1);
    finish_hdr(t1, 0, 1'b0, dummy);

    // T6: five back-to-back good headers; 2-bit counters saturate at 3
    for (int i = 0; i < 5; i++) begin
      start_hdr(t1);
      finish_hdr(t1, 0, (i < 4), t1);
    end

    // Random headers with random back-pressure and back-to-back offers
    cur = rand_hdr();
    for (int i = 0; i < 40; i++) begin
      start_hdr(cur);
      nxt = rand_hdr();
      stall = $urandom_range(0, 3);
      hold = 1'($urandom_range(0, 1));
      finish_hdr(cur, stall, hold, nxt);
      cur = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
